// File: rtl/rv64g_l2_pkg.sv
// Shared L2 geometry and allocation-sequencer state encoding.
// Geometry is fixed to match the 16-way PLRU.
package rv64g_l2_pkg;

    localparam int NUM_SETS = 256;
    localparam int NUM_WAYS = 16;
    localparam int TAG_W    = 42;
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int ADDR_W   = TAG_W + SET_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_TAG,
        S_PICK,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_COMMIT
    } alloc_state_e;

endpackage

// File: rtl/rv64g_l2_alloc_ctrl.sv
// L2 miss-allocation sequencer: read tags, pick PLRU victim,
// write back dirty victim, refill, commit tag and touch PLRU.
module rv64g_l2_alloc_ctrl
    import rv64g_l2_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [SET_W-1:0]          req_set_i,
    input  logic [TAG_W-1:0]          req_tag_i,
    output logic                      tag_rd_en_o,
    output logic [SET_W-1:0]          tag_rd_set_o,
    input  logic [NUM_WAYS-1:0]       tag_valid_i,
    input  logic [NUM_WAYS-1:0]       tag_dirty_i,
    input  logic [NUM_WAYS*TAG_W-1:0] tag_tags_i,
    output logic [SET_W-1:0]          plru_set_o,
    output logic [NUM_WAYS-1:0]       plru_valid_o,
    input  logic [WAY_W-1:0]          plru_victim_i,
    output logic                      plru_access_o,
    output logic [WAY_W-1:0]          plru_used_way_o,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [ADDR_W-1:0]         wb_addr_o,
    output logic [WAY_W-1:0]          wb_way_o,
    input  logic                      wb_done_i,
    output logic                      fill_valid_o,
    input  logic                      fill_ready_i,
    output logic [ADDR_W-1:0]         fill_addr_o,
    output logic [WAY_W-1:0]          fill_way_o,
    input  logic                      fill_done_i,
    output logic                      tag_we_o,
    output logic [SET_W-1:0]          tag_wr_set_o,
    output logic [WAY_W-1:0]          tag_wr_way_o,
    output logic [TAG_W-1:0]          tag_wr_tag_o,
    output logic                      done_o,
    output logic [WAY_W-1:0]          done_way_o
);

    alloc_state_e state_q, state_d;

    logic [SET_W-1:0]          set_q;
    logic [TAG_W-1:0]          tag_q;
    logic [NUM_WAYS-1:0]       valid_q;
    logic [NUM_WAYS-1:0]       dirty_q;
    logic [NUM_WAYS*TAG_W-1:0] tags_q;
    logic [WAY_W-1:0]          vway_q;
    logic [TAG_W-1:0]          vtag_q;
    logic                      accept;
    logic                      commit;

    assign accept = (state_q == S_IDLE) && req_valid_i;
    assign commit = (state_q == S_COMMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (req_valid_i) state_d = S_RD_TAG;
            S_RD_TAG:    state_d = S_PICK;
            S_PICK: begin
                // only a line that is both valid and dirty needs draining
                if (valid_q[plru_victim_i] && dirty_q[plru_victim_i])
                    state_d = S_WB_REQ;
                else
                    state_d = S_FILL_REQ;
            end
            S_WB_REQ:    if (wb_ready_i) state_d = S_WB_WAIT;
            S_WB_WAIT:   if (wb_done_i) state_d = S_FILL_REQ;
            S_FILL_REQ:  if (fill_ready_i) state_d = S_FILL_WAIT;
            S_FILL_WAIT: if (fill_done_i) state_d = S_COMMIT;
            S_COMMIT:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            set_q   <= '0;
            tag_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            tags_q  <= '0;
            vway_q  <= '0;
            vtag_q  <= '0;
        end else begin
            if (accept) begin
                set_q <= req_set_i;
                tag_q <= req_tag_i;
            end
            if (state_q == S_RD_TAG) begin
                valid_q <= tag_valid_i;
                dirty_q <= tag_dirty_i;
                tags_q  <= tag_tags_i;
            end
            if (state_q == S_PICK) begin
                vway_q <= plru_victim_i;
                vtag_q <= tags_q[plru_victim_i*TAG_W +: TAG_W];
            end
        end
    end

    // tag read is issued in the accept cycle, before set_q is loaded
    assign req_ready_o     = (state_q == S_IDLE);
    assign tag_rd_en_o     = accept;
    assign tag_rd_set_o    = accept ? req_set_i : set_q;

    assign plru_set_o      = set_q;
    assign plru_valid_o    = valid_q;
    assign plru_access_o   = commit;
    assign plru_used_way_o = vway_q;

    assign wb_valid_o      = (state_q == S_WB_REQ);
    assign wb_addr_o       = {vtag_q, set_q};
    assign wb_way_o        = vway_q;

    assign fill_valid_o    = (state_q == S_FILL_REQ);
    assign fill_addr_o     = {tag_q, set_q};
    assign fill_way_o      = vway_q;

    assign tag_we_o        = commit;
    assign tag_wr_set_o    = set_q;
    assign tag_wr_way_o    = vway_q;
    assign tag_wr_tag_o    = tag_q;
    assign done_o          = commit;
    assign done_way_o      = vway_q;

endmodule

// File: tb/tb_rv64g_l2_alloc_ctrl.sv
// Scoreboard bench for the L2 allocation sequencer.
// Directed misses; monitor pops expected wb/fill/commit events.
module tb_rv64g_l2_alloc_ctrl;
    import rv64g_l2_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [SET_W-1:0]          req_set_i;
    logic [TAG_W-1:0]          req_tag_i;
    logic                      tag_rd_en_o;
    logic [SET_W-1:0]          tag_rd_set_o;
    logic [NUM_WAYS-1:0]       tag_valid_i;
    logic [NUM_WAYS-1:0]       tag_dirty_i;
    logic [NUM_WAYS*TAG_W-1:0] tag_tags_i;
    logic [SET_W-1:0]          plru_set_o;
    logic [NUM_WAYS-1:0]       plru_valid_o;
    logic [WAY_W-1:0]          plru_victim_i;
    logic                      plru_access_o;
    logic [WAY_W-1:0]          plru_used_way_o;
    logic                      wb_valid_o;
    logic                      wb_ready_i;
    logic [ADDR_W-1:0]         wb_addr_o;
    logic [WAY_W-1:0]          wb_way_o;
    logic                      wb_done_i;
    logic                      fill_valid_o;
    logic                      fill_ready_i;
    logic [ADDR_W-1:0]         fill_addr_o;
    logic [WAY_W-1:0]          fill_way_o;
    logic                      fill_done_i;
    logic                      tag_we_o;
    logic [SET_W-1:0]          tag_wr_set_o;
    logic [WAY_W-1:0]          tag_wr_way_o;
    logic [TAG_W-1:0]          tag_wr_tag_o;
    logic                      done_o;
    logic [WAY_W-1:0]          done_way_o;

    always #5 clk_i = ~clk_i;

    rv64g_l2_alloc_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_set_i(req_set_i), .req_tag_i(req_tag_i),
        .tag_rd_en_o(tag_rd_en_o), .tag_rd_set_o(tag_rd_set_o),
        .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i),
        .tag_tags_i(tag_tags_i),
        .plru_set_o(plru_set_o), .plru_valid_o(plru_valid_o),
        .plru_victim_i(plru_victim_i), .plru_access_o(plru_access_o),
        .plru_used_way_o(plru_used_way_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_addr_o(wb_addr_o), .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
        .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i),
        .fill_addr_o(fill_addr_o), .fill_way_o(fill_way_o),
        .fill_done_i(fill_done_i),
        .tag_we_o(tag_we_o), .tag_wr_set_o(tag_wr_set_o),
        .tag_wr_way_o(tag_wr_way_o), .tag_wr_tag_o(tag_wr_tag_o),
        .done_o(done_o), .done_way_o(done_way_o)
    );

    localparam logic [1:0] K_WB     = 2'd0;
    localparam logic [1:0] K_FILL   = 2'd1;
    localparam logic [1:0] K_COMMIT = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [WAY_W-1:0]  way;
        logic [7:0]        lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_n = 0;
    int   fill_acc_n = 0;
    int   tmo_n = 0;
    bit   end_flag = 0;

    int   wb_hold = 0;
    bit   fill_block = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // handshake responder: ready after wb_hold cycles, done one cycle after accept
    initial begin
        bit wb_pend;
        bit fill_pend;
        int wh;
        wb_pend = 0; fill_pend = 0; wh = 0;
        wb_ready_i = 0; wb_done_i = 0; fill_ready_i = 0; fill_done_i = 0;
        forever begin
            @(posedge clk_i); #1;
            wb_done_i = wb_pend;
            wb_pend = 0;
            fill_done_i = fill_pend && !fill_block;
            if (fill_done_i) fill_pend = 0;
            if (wb_valid_o && wh < wb_hold) begin
                wb_ready_i = 0;
                wh++;
            end else begin
                wb_ready_i = wb_valid_o;
                if (wb_valid_o) wh = 0;
            end
            fill_ready_i = fill_valid_o;
            @(negedge clk_i);
            if (wb_valid_o && wb_ready_i) wb_pend = 1;
            if (fill_valid_o && fill_ready_i) fill_pend = 1;
        end
    end

    // monitor / scoreboard
    always @(negedge clk_i) begin
        static bit               rst_seen = 0;
        static bit               wb_prev_v = 0;
        static bit               wb_prev_acc = 0;
        static bit               wb_phase = 0;
        static bit               end_done = 0;
        static int               tmo_seen = 0;
        static int               acc_cyc = 0;
        static logic [ADDR_W-1:0] prev_addr = '0;
        static logic [WAY_W-1:0]  prev_way = '0;
        exp_t e;
        if (rst_i) begin
            q.delete();
            rst_seen = 1;
            wb_prev_v = 0;
            wb_prev_acc = 0;
            wb_phase = 0;
        end else begin
            if (rst_seen) begin
                rst_seen = 0;
                chk("rst_req_ready", req_ready_o, 1);
                chk("rst_strobes", {tag_rd_en_o, wb_valid_o, fill_valid_o,
                    tag_we_o, plru_access_o, done_o}, 0);
                chk("rst_wb_addr", wb_addr_o, 0);
                chk("rst_fill_addr", fill_addr_o, 0);
                chk("rst_ways", {fill_way_o, wb_way_o, done_way_o}, 0);
                chk("rst_plru", {plru_set_o, plru_valid_o}, 0);
                chk("rst_rd_set", tag_rd_set_o, 0);
            end
            if (tmo_n != tmo_seen) begin
                chk("timeout", tmo_n, tmo_seen);
                tmo_seen = tmo_n;
            end
            if (req_valid_i && req_ready_o) begin
                acc_cyc = cyc;
                chk("tag_rd_en", tag_rd_en_o, 1);
                chk("tag_rd_set", tag_rd_set_o, req_set_i);
            end
            if (wb_prev_v && !wb_prev_acc) begin
                chk("wb_hold_valid", wb_valid_o, 1);
                chk("wb_hold_addr", wb_addr_o, prev_addr);
                chk("wb_hold_way", wb_way_o, prev_way);
            end
            if (wb_valid_o && wb_ready_i) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wb_unexpected: got wb %0h required none", wb_addr_o);
                end else begin
                    e = q.pop_front();
                    chk("wb_kind", K_WB, e.kind);
                    chk("wb_addr", wb_addr_o, e.addr);
                    chk("wb_way", wb_way_o, e.way);
                end
            end
            if (fill_valid_o && fill_ready_i) begin
                fill_acc_n++;
                chk("fill_before_wb_done", wb_phase, 0);
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL fill_unexpected: got fill %0h required none", fill_addr_o);
                end else begin
                    e = q.pop_front();
                    chk("fill_kind", K_FILL, e.kind);
                    chk("fill_addr", fill_addr_o, e.addr);
                    chk("fill_way", fill_way_o, e.way);
                end
            end
            if (done_o || tag_we_o || plru_access_o) begin
                done_n++;
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL commit_unexpected: got way %0h required none", done_way_o);
                end else begin
                    e = q.pop_front();
                    chk("commit_kind", K_COMMIT, e.kind);
                    chk("commit_strobes", {done_o, tag_we_o, plru_access_o}, 3'b111);
                    chk("tag_wr_way", tag_wr_way_o, e.way);
                    chk("plru_used_way", plru_used_way_o, e.way);
                    chk("done_way", done_way_o, e.way);
                    chk("tag_wr_set", tag_wr_set_o, e.addr[SET_W-1:0]);
                    chk("plru_set", plru_set_o, e.addr[SET_W-1:0]);
                    chk("tag_wr_tag", tag_wr_tag_o, e.addr[ADDR_W-1:SET_W]);
                    chk("latency", cyc - acc_cyc, e.lat);
                end
            end
            if (wb_valid_o) wb_phase = 1;
            else if (wb_done_i) wb_phase = 0;
            wb_prev_v = wb_valid_o;
            wb_prev_acc = wb_valid_o && wb_ready_i;
            prev_addr = wb_addr_o;
            prev_way = wb_way_o;
            if (end_flag && !end_done) begin
                end_done = 1;
                chk("queue_empty", q.size(), 0);
            end
        end
    end

    // call right after a posedge; returns right after a posedge
    task automatic run(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                       input logic [15:0] v, input logic [15:0] d,
                       input logic [3:0] vic, input logic [TAG_W-1:0] vtag,
                       input bit exp_wb, input int lat, input bit wait_done);
        int d0;
        #1;
        for (int w = 0; w < NUM_WAYS; w++)
            tag_tags_i[w*TAG_W +: TAG_W] = (w == vic) ? vtag : TAG_W'(12'h100 + w);
        tag_valid_i = v;
        tag_dirty_i = d;
        plru_victim_i = vic;
        if (exp_wb) q.push_back('{K_WB, {vtag, s}, vic, 8'd0});
        q.push_back('{K_FILL, {t, s}, vic, 8'd0});
        q.push_back('{K_COMMIT, {t, s}, vic, 8'(lat)});
        d0 = done_n;
        req_valid_i = 1;
        req_set_i = s;
        req_tag_i = t;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        if (wait_done) begin
            for (int i = 0; i < 200 && done_n == d0; i++) @(posedge clk_i);
            if (done_n == d0) tmo_n++;
        end
    endtask

    initial begin
        int f0;
        rst_i = 1; req_valid_i = 0; req_set_i = '0; req_tag_i = '0;
        tag_valid_i = '0; tag_dirty_i = '0; tag_tags_i = '0; plru_victim_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        @(posedge clk_i);
        run(8'h05, 42'h123, 16'h0000, 16'h0000, 4'd0, 42'h100, 0, 5, 1);
        run(8'h3C, 42'h777, 16'hFFFF, 16'h0200, 4'd9, 42'hAB, 1, 7, 1);
        run(8'h80, 42'h55, 16'hFFFF, 16'hFFF7, 4'd3, 42'h333, 0, 5, 1);
        wb_hold = 10;
        run(8'h11, 42'h200_0000_0001, 16'hFFFF, 16'h0004, 4'd2,
            42'h3FF_FFFF_FFFF, 1, 17, 1);
        wb_hold = 0;
        fill_block = 1;
        f0 = fill_acc_n;
        run(8'h22, 42'h99, 16'h0000, 16'h0000, 4'd0, 42'h100, 0, 5, 0);
        for (int i = 0; i < 50 && fill_acc_n == f0; i++) @(posedge clk_i);
        if (fill_acc_n == f0) tmo_n++;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1;
        @(posedge clk_i);
        #1 rst_i = 0;
        fill_block = 0;
        @(posedge clk_i);
        run(8'hFF, 42'h3FF_FFFF_FFFF, 16'h00FF, 16'h0000, 4'd8, 42'h100, 0, 5, 1);
        run(8'h07, 42'hBEEF, 16'hFF7F, 16'hFFFF, 4'd7, 42'h777, 0, 5, 1);
        end_flag = 1;
        repeat (3) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
